// File: rtl/if_align_stage.sv
// IF/ID alignment stage: splits word-aligned 32-bit fetches into a registered
// stream of 16-bit (RVC) and 32-bit instructions, including word-straddling ones.
module if_align_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        id_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    output logic [31:0] out_ir,
    output logic [31:0] out_pc,
    output logic        out_is_c
);

    typedef enum logic [1:0] {
        S_ALIGN = 2'd0,
        S_HALF  = 2'd1,
        S_MIS   = 2'd2
    } state_t;

    localparam logic [31:0] RESET_WORD  = {RESET_PC[31:2], 2'b00};
    localparam state_t      RESET_STATE = RESET_PC[1] ? S_MIS : S_ALIGN;

    function automatic logic is_compressed(input logic [15:0] hw);
        return (hw[1:0] != 2'b11);
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] fetch_addr_r;
    logic [31:0] fetch_nxt_s;
    logic [15:0] hb_data_r;
    logic [15:0] hb_data_nxt_s;
    logic [31:0] hb_pc_r;
    logic [31:0] hb_pc_nxt_s;
    logic        emit_valid_s;
    logic [31:0] emit_ir_s;
    logic [31:0] emit_pc_s;
    logic        emit_c_s;
    logic        adv_s;

    assign imem_addr = fetch_addr_r;
    assign adv_s     = !out_valid || id_ready;

    // Next-state and instruction-extraction logic for the alignment FSM
    always_comb begin
        state_nxt_s   = state_r;
        fetch_nxt_s   = fetch_addr_r;
        hb_data_nxt_s = hb_data_r;
        hb_pc_nxt_s   = hb_pc_r;
        emit_valid_s  = 1'b0;
        emit_ir_s     = 32'h0000_0000;
        emit_pc_s     = 32'h0000_0000;
        emit_c_s      = 1'b0;
        case (state_r)
            S_ALIGN: begin
                emit_valid_s = 1'b1;
                emit_pc_s    = fetch_addr_r;
                fetch_nxt_s  = fetch_addr_r + 32'd4;
                if (is_compressed(imem_rdata[15:0])) begin
                    emit_ir_s     = {16'h0000, imem_rdata[15:0]};
                    emit_c_s      = 1'b1;
                    hb_data_nxt_s = imem_rdata[31:16];
                    hb_pc_nxt_s   = fetch_addr_r + 32'd2;
                    state_nxt_s   = S_HALF;
                end else begin
                    emit_ir_s   = imem_rdata;
                    emit_c_s    = 1'b0;
                    state_nxt_s = S_ALIGN;
                end
            end
            S_HALF: begin
                emit_valid_s = 1'b1;
                emit_pc_s    = hb_pc_r;
                if (is_compressed(hb_data_r)) begin
                    // buffered halfword is a whole instruction; memory word is not consumed
                    emit_ir_s   = {16'h0000, hb_data_r};
                    emit_c_s    = 1'b1;
                    state_nxt_s = S_ALIGN;
                end else begin
                    emit_ir_s     = {imem_rdata[15:0], hb_data_r};
                    emit_c_s      = 1'b0;
                    hb_data_nxt_s = imem_rdata[31:16];
                    hb_pc_nxt_s   = hb_pc_r + 32'd4;
                    fetch_nxt_s   = fetch_addr_r + 32'd4;
                    state_nxt_s   = S_HALF;
                end
            end
            S_MIS: begin
                hb_data_nxt_s = imem_rdata[31:16];
                hb_pc_nxt_s   = fetch_addr_r + 32'd2;
                fetch_nxt_s   = fetch_addr_r + 32'd4;
                state_nxt_s   = S_HALF;
            end
            default: begin
                state_nxt_s = S_ALIGN;
            end
        endcase
    end

    // State, halfword buffer and registered output; flush overrides any stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RESET_STATE;
            fetch_addr_r <= RESET_WORD;
            hb_data_r    <= 16'h0000;
            hb_pc_r      <= 32'h0000_0000;
            out_valid    <= 1'b0;
            out_ir       <= 32'h0000_0000;
            out_pc       <= 32'h0000_0000;
            out_is_c     <= 1'b0;
        end else if (flush) begin
            state_r      <= flush_pc[1] ? S_MIS : S_ALIGN;
            fetch_addr_r <= {flush_pc[31:2], 2'b00};
            hb_data_r    <= 16'h0000;
            hb_pc_r      <= 32'h0000_0000;
            out_valid    <= 1'b0;
        end else if (adv_s) begin
            state_r      <= state_nxt_s;
            fetch_addr_r <= fetch_nxt_s;
            hb_data_r    <= hb_data_nxt_s;
            hb_pc_r      <= hb_pc_nxt_s;
            out_valid    <= emit_valid_s;
            if (emit_valid_s) begin
                out_ir   <= emit_ir_s;
                out_pc   <= emit_pc_s;
                out_is_c <= emit_c_s;
            end
        end
    end

endmodule

// File: tb/tb_if_align_stage.sv
// Self-checking bench for if_align_stage: directed cases plus random stream,
// checked against a program-order model reading halfwords from the memory image.
module tb_if_align_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic [31:0] out_ir;
    logic [31:0] out_pc;
    logic        out_is_c;

    logic [31:0] mem [64];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mpc;
    int          bub;
    logic [31:0] mis_word;

    if_align_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .id_ready  (id_ready),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .out_valid (out_valid),
        .out_ir    (out_ir),
        .out_pc    (out_pc),
        .out_is_c  (out_is_c)
    );

    assign imem_rdata = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Drive one cycle of inputs, clock it, and check the result against the model.
    task automatic cycle(input logic rdy, input logic fl, input logic [31:0] fpc);
        logic        pv, pc_c;
        logic [31:0] pir, ppc, pa;
        logic [15:0] h0;
        logic        c;
        logic [31:0] eir;
        pv = out_valid; pir = out_ir; ppc = out_pc; pc_c = out_is_c; pa = imem_addr;
        id_ready = rdy; flush = fl; flush_pc = fpc;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (fl) begin
            check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
            check_eq("flush_addr", imem_addr, {fpc[31:2], 2'b00});
            mpc      = {fpc[31:1], 1'b0};
            bub      = fpc[1] ? 1 : 0;
            mis_word = {fpc[31:2], 2'b00};
        end else if (pv && !rdy) begin
            check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
            check_eq("stall_ir", out_ir, pir);
            check_eq("stall_pc", out_pc, ppc);
            check_eq("stall_is_c", {31'd0, out_is_c}, {31'd0, pc_c});
            check_eq("stall_addr", imem_addr, pa);
        end else if (bub > 0) begin
            check_eq("mis_valid", {31'd0, out_valid}, 32'd0);
            check_eq("mis_addr", imem_addr, mis_word + 32'd4);
            bub = 0;
        end else begin
            h0  = hw_at(mpc);
            c   = (h0[1:0] != 2'b11);
            eir = c ? {16'h0000, h0} : {hw_at(mpc + 32'd2), h0};
            check_eq("valid", {31'd0, out_valid}, 32'd1);
            check_eq("pc", out_pc, mpc);
            check_eq("ir", out_ir, eir);
            check_eq("is_c", {31'd0, out_is_c}, {31'd0, c});
            mpc = mpc + (c ? 32'd2 : 32'd4);
        end
    endtask

    // Assert reset between edges, check the immediate effect, release mid-cycle.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0000_0000);
        check_eq("rst_ir", out_ir, 32'd0);
        check_eq("rst_pc", out_pc, 32'd0);
        check_eq("rst_is_c", {31'd0, out_is_c}, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        mpc = 32'h0000_0000;
        bub = 0;
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
    endtask

    initial begin
        rst_n = 1'b0; id_ready = 1'b1; flush = 1'b0; flush_pc = 32'd0;
        mpc = 32'd0; bub = 0; mis_word = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;

        // aligned 32-bit stream
        mem[0] = 32'h0000_0013; mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113; mem[3] = 32'h0030_0193;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'd0);
            check_eq("align_pc", out_pc, 32'(i * 4));
            check_eq("align_imem", imem_addr, 32'((i + 1) * 4));
        end

        // compressed pair in one word
        mem[0] = {16'h4505, 16'h4581};
        do_reset();
        cycle(1'b1, 1'b0, 32'd0);
        check_eq("pair0_ir", out_ir, 32'h0000_4581);
        check_eq("pair0_imem", imem_addr, 32'h4);
        cycle(1'b1, 1'b0, 32'd0);
        check_eq("pair1_ir", out_ir, 32'h0000_4505);
        check_eq("pair1_pc", out_pc, 32'h2);
        check_eq("pair1_imem", imem_addr, 32'h4);

        // straddling 32-bit instruction
        mem[0] = {16'h0513, 16'h4581};
        mem[1] = {16'h4505, 16'h00A0};
        do_reset();
        cycle(1'b1, 1'b0, 32'd0);
        check_eq("str0_ir", out_ir, 32'h0000_4581);
        cycle(1'b1, 1'b0, 32'd0);
        check_eq("str1_ir", out_ir, 32'h00A0_0513);
        check_eq("str1_pc", out_pc, 32'h2);
        check_eq("str1_is_c", {31'd0, out_is_c}, 32'd0);
        cycle(1'b1, 1'b0, 32'd0);
        check_eq("str2_pc", out_pc, 32'h6);
        check_eq("str2_ir", out_ir, 32'h0000_4505);

        // stall mid-stream, then flush to an offset target while stalled
        randomize_mem();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 32'h0000_0102);
        check_eq("fl_imem0", imem_addr, 32'h100);
        cycle(1'b1, 1'b0, 32'd0);
        check_eq("fl_imem1", imem_addr, 32'h104);
        cycle(1'b1, 1'b0, 32'd0);
        check_eq("fl_first_pc", out_pc, 32'h102);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'd0);

        // asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'd0);

        // address wrap across the top of memory
        cycle(1'b1, 1'b1, 32'hFFFF_FFFA);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'd0);

        // randomized stream with stalls and redirects
        for (int r = 0; r < 4; r++) begin
            randomize_mem();
            do_reset();
            for (int i = 0; i < 600; i++) begin
                logic        rdy, fl;
                logic [31:0] fpc;
                rdy = ($urandom_range(0, 3) != 0);
                fl  = ($urandom_range(0, 19) == 0);
                fpc = $urandom & 32'hFFFF_FFFE;
                cycle(rdy, fl, fpc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_align_stage.md
# if_align_stage

Fetch-side IF/ID stage for the compressed-instruction core. It reads word-aligned 32-bit fetches from a single-cycle instruction memory and splits them into a stream of 16-bit (RVC) and 32-bit instructions, including 32-bit instructions that straddle a word boundary. It registers each instruction with its PC, and supports decode back-pressure and a redirect (flush). Its `out_ir` feeds the decompressor/decode stage, whose 32-bit IR drives the immediate generator.

## Interface
- `RESET_PC`, default 32'h0000_0000: first instruction address after reset; bit 0 is ignored.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr` out 32: word address to instruction memory; bits [1:0] are always 0.
- `imem_rdata` in 32: memory word at `imem_addr`, valid in the same cycle (combinational read).
- `id_ready` in 1: decode accepts `out_*` this cycle; low means stall.
- `flush` in 1: redirect request from EX.
- `flush_pc` in 32: redirect target; bit 0 is ignored.
- `out_valid` out 1: `out_*` holds a real instruction.
- `out_ir` out 32: the instruction. A 32-bit instruction is placed as-is. A compressed instruction is placed as {16'h0, hw}.
- `out_pc` out 32: address of the instruction.
- `out_is_c` out 1: 1 when the instruction is 16-bit.

## Operation
- Internal registers: `fetch_addr` (word aligned), `hb_data[15:0]`, `hb_pc`, and a 3-state FSM. `imem_addr = fetch_addr`.
- A halfword is compressed iff its bits [1:0] != 2'b11.
- `adv = !out_valid || id_ready`. The output register and all state update only when `adv` is true, except on flush.
- **S_ALIGN** (buffer empty, next PC = `fetch_addr`). Let w = `imem_rdata`.
  - If w[1:0]==2'b11: emit the 32-bit instruction w at `fetch_addr`. Set `fetch_addr += 4`. Stay in S_ALIGN.
  - Otherwise: emit compressed w[15:0] at `fetch_addr`. Set `hb_data = w[31:16]`, `hb_pc = fetch_addr+2`, `fetch_addr += 4`. Go to S_HALF.
- **S_HALF** (halfword buffered, next PC = `hb_pc`).
  - If `hb_data` is compressed: emit it with no memory consumption. `fetch_addr` is unchanged. Go to S_ALIGN.
  - Otherwise: emit {`imem_rdata[15:0]`, `hb_data`} at `hb_pc` as a 32-bit instruction. Set `hb_data = imem_rdata[31:16]`, `hb_pc += 4`, `fetch_addr += 4`. Stay in S_HALF.
- **S_MIS** (entered after a redirect to PC[1]==1).
  - Set `hb_data = imem_rdata[31:16]`, `hb_pc = fetch_addr+2`, `fetch_addr += 4`. Go to S_HALF.
  - No instruction is emitted; `out_valid` goes to 0 if `adv`.
- **Flush** has the highest priority and ignores `id_ready`. On the next edge:
  - `out_valid=0`.
  - `fetch_addr = {flush_pc[31:2],2'b00}`.
  - State becomes S_MIS if `flush_pc[1]`, else S_ALIGN.
  - The halfword buffer is discarded.
- **Reset** sets the same state as a flush to `RESET_PC`. It also clears `out_valid`, `out_ir`, `out_pc`, `out_is_c` and `hb_data` to 0.
- PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.

## Timing
- Latency is one cycle: the word on `imem_rdata` in cycle N appears on `out_*` after edge N+1.
- Throughput is one instruction per cycle in S_ALIGN and S_HALF.
- A redirect to an aligned target costs 1 bubble cycle (the flush cycle itself). A redirect to a halfword-offset target costs 2 bubble cycles (flush cycle plus S_MIS).
- Stall: while `out_valid && !id_ready`, `out_*`, `fetch_addr`, FSM and buffer are frozen, and `imem_addr` is held stable.
- `flush` together with a stall: the flush wins and the stalled instruction is dropped.
- Asynchronous reset mid-stream takes effect immediately with no clock edge. The first instruction after release appears at edge 1 (aligned `RESET_PC`) or edge 2 (offset `RESET_PC`).

## Test plan
- **Aligned 32-bit stream.** Reset with `RESET_PC=0`; memory holds 32-bit words at 0x0, 0x4 and 0x8. Required: `out_pc` = 0, 4, 8 on consecutive cycles, `out_is_c=0`, `imem_addr` = 0, 4, 8, C.
- **Compressed pair in one word.** Word 0 = {16'h4505, 16'h4581}. Required: out {16'h0,16'h4581} at pc 0, then {16'h0,16'h4505} at pc 2, both `out_is_c=1`. `imem_addr` stays 4 during the second emit.
- **Straddling 32-bit instruction.** Word 0 = {16'h0513 lower half of a 32-bit op, 16'h4581}; word 4 = {16'h4505, 16'h00A0}. Required:
  - pc 0: compressed 16'h4581.
  - pc 2: `out_ir=32'h00A0_0513`, `out_is_c=0`.
  - pc 6: compressed 16'h4505.
- **Stall.** Hold `id_ready=0` for 3 cycles mid-stream. Required: `out_*` and `imem_addr` are constant for those cycles, and there is no skipped or duplicated PC after release.
- **Flush to offset target.** Pulse `flush` with `flush_pc=0x102` while stalled. Required:
  - `out_valid=0` for 2 cycles.
  - `imem_addr` = 0x100, then 0x104.
  - First valid output has `out_pc=0x102`.
- **Asynchronous reset mid-stream.** Assert `rst_n=0` between clock edges. Required: `out_valid=0` and `imem_addr=RESET_PC&~3` immediately, and the stream restarts correctly after release.
